// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the SRAM request controller.
package sram_ctrl_pkg;

  // Default SRAM geometry.
  localparam int SRAM_ADDR_WIDTH = 14;
  localparam int SRAM_DATA_WIDTH = 32;

  // Response FIFO geometry: two entries cover one read landing while another is issued.
  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_FIFO_CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  // Controller states.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_state_e;

  // Plain constants for the state register, kept for older tooling.
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN  = RUN;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response FIFO with combinational head, push/pop and occupancy count.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic [RSP_FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);

  logic [WIDTH-1:0]          mem_reg [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_reg;
  logic [PTR_W-1:0]          rd_ptr_reg;
  logic [RSP_FIFO_CNT_W-1:0] count_reg;
  logic [RSP_FIFO_CNT_W-1:0] count_next;
  logic                      full;
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == RSP_FIFO_CNT_W'(RSP_FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage entries carry no reset; contents only matter once counted.
  generate
    for (genvar gi = 0; gi < RSP_FIFO_DEPTH; gi++) begin : g_entry
      // Capture write data into this entry when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // The request-side flow control must never let a response arrive with nowhere to go.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front end for a single-port synchronous SRAM with an
// in-order read response path. Optional macro SRAM_INIT_EN adds a post-reset
// pass that writes zero to every address before requests are accepted.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  // request side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  // response side
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  // SRAM side
  output logic                    CEN,
  output logic                    GWEN,
  output logic [DATA_WIDTH/8-1:0] BEN,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic [DATA_WIDTH-1:0]   D,
  input  logic [DATA_WIDTH-1:0]   Q
);

  localparam int BW = DATA_WIDTH / 8;

`ifdef SRAM_INIT_EN
  localparam logic [0:0] RESET_STATE = ST_INIT;
`else
  localparam logic [0:0] RESET_STATE = ST_RUN;
`endif

  logic [0:0]                state_reg;
  logic [0:0]                state_next;
  logic [ADDR_WIDTH-1:0]     init_cnt_reg;
  logic [ADDR_WIDTH-1:0]     init_cnt_next;
  logic                      rd_pending_reg;
  logic                      rd_pending_next;

  logic                      in_init;
  logic                      in_run;
  logic                      accept;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_empty;
  logic [RSP_FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0]     fifo_rdata;
  logic [2:0]                occupancy;
  logic [BW-1:0]             ben_acc;

  // Reset overrides the state so the pins are quiet for the whole reset cycle.
  assign in_init = !rst && (state_reg == ST_INIT);
  assign in_run  = !rst && (state_reg == ST_RUN);

  // Reads in flight that still need a FIFO slot, after this cycle's pop leaves.
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending_reg} - {2'b00, fifo_pop};

  assign req_ready = in_run && (occupancy < 3'd2);
  assign accept    = req_valid && req_ready;

  // Q belongs to the read issued last cycle; a reset in between throws it away.
  assign fifo_push = rd_pending_reg && !rst;

  assign rsp_valid = !rst && !fifo_empty;
  assign rsp_rdata = fifo_rdata;
  assign init_done = in_run;

  // Byte enables during an access: writes honour req_be, reads enable every lane.
  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_ben
      assign ben_acc[gi] = req_we ? ~req_be[gi] : 1'b0;
    end
  endgenerate

  // SRAM pin mux: idle under reset, zero-fill during INIT, pass-through in RUN.
  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    BEN  = '1;
    A    = '0;
    D    = '0;
    if (in_init) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      BEN  = '0;
      A    = init_cnt_reg;
      D    = '0;
    end else if (in_run) begin
      A = req_addr;
      D = req_wdata;
      if (accept) begin
        CEN  = 1'b0;
        GWEN = ~req_we;
        BEN  = ben_acc;
      end
    end
  end

  // Next-state logic: INIT walks every address once, then hands over to RUN.
  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    rd_pending_next = accept && !req_we;
    if (state_reg == ST_INIT) begin
      init_cnt_next = init_cnt_reg + 1'b1;
      if (init_cnt_reg == '1) begin
        state_next = ST_RUN;
      end
    end
  end

  // Control registers; reset restarts INIT from address zero and drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RESET_STATE;
      init_cnt_reg   <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      rd_pending_reg <= rd_pending_next;
    end
  end

  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (Q),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM device plus a transaction-level
// reference model (memory image and queue of outstanding reads).
module tb_sram_req_ctrl;

`ifdef SRAM_INIT_EN
  localparam int AW          = 4;
  localparam int INIT_CYCLES = 1 << AW;
`else
  localparam int AW          = 8;
  localparam int INIT_CYCLES = 0;
`endif
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [BW-1:0] req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          CEN;
  logic          GWEN;
  logic [BW-1:0] BEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .BEN       (BEN),
    .A         (A),
    .D         (D),
    .Q         (Q)
  );

  // ---------------- SRAM device model ----------------
  logic [DW-1:0] sram_mem [DEPTH];

  always @(posedge clk) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int b = 0; b < BW; b++)
          if (!BEN[b]) sram_mem[A][b*8 +: 8] <= D[b*8 +: 8];
      end else begin
        Q <= sram_mem[A];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc = 0;
  int            since_rst = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_rsp = 0;
  logic [DW-1:0] last_rdata = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Per-cycle expectations, sampled mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    logic                       rv_exp;
    logic                       pop_exp;
    logic                       ready_exp;
    logic                       acc_exp;
    int                         outstanding;
    logic [2+BW+AW+DW-1:0]      pins_exp;
    if (rst) begin
      check("rst_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_pins", {CEN, GWEN, BEN, A, D}, {2'b11, {BW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}});
      exp_q.delete();
      since_rst = 0;
    end else if (since_rst < INIT_CYCLES) begin
      check("init_ready", req_ready, 1'b0);
      check("init_done_low", init_done, 1'b0);
      check("init_pins", {CEN, GWEN, BEN, A, D}, {2'b00, {BW{1'b0}}, AW'(since_rst), {DW{1'b0}}});
      ref_mem[since_rst] = '0;
      since_rst++;
    end else begin
      // A read's data is visible two cycles after its accept cycle, in order.
      rv_exp      = (exp_q.size() > 0) && (cyc - exp_q[0].acc_cyc >= 2);
      pop_exp     = rv_exp && rsp_ready;
      outstanding = exp_q.size() - (pop_exp ? 1 : 0);
      ready_exp   = (outstanding < 2);
      acc_exp     = req_valid && ready_exp;
      check("ready", req_ready, ready_exp);
      check("rsp_valid", rsp_valid, rv_exp);
      check("init_done", init_done, 1'b1);
      if (acc_exp)
        pins_exp = {1'b0, ~req_we, (req_we ? ~req_be : {BW{1'b0}}), req_addr, req_wdata};
      else
        pins_exp = {1'b1, 1'b1, {BW{1'b1}}, req_addr, req_wdata};
      check(acc_exp ? "pins_acc" : "pins_idle", {CEN, GWEN, BEN, A, D}, pins_exp);
      if (pop_exp) begin
        check("rdata", rsp_rdata, exp_q[0].data);
        $display("rsp  #%0d data=%08h cycle=%0d", n_rsp, rsp_rdata, cyc);
        last_rdata = rsp_rdata;
        n_rsp++;
        void'(exp_q.pop_front());
      end
      if (acc_exp) begin
        if (req_we) begin
          for (int b = 0; b < BW; b++)
            if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
          $display("wr   addr=%0h be=%0h data=%08h cycle=%0d", req_addr, req_be, req_wdata, cyc);
        end else begin
          exp_q.push_back('{data: ref_mem[req_addr], acc_cyc: cyc});
          $display("rd   addr=%0h cycle=%0d", req_addr, cyc);
        end
      end
      since_rst++;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Hold a request until the controller takes it (bounded).
  task automatic send(input logic we, input logic [BW-1:0] be,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    int   n;
    set_req(1'b1, we, be, a, d);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      n++;
    end
    check("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    @(negedge clk);
    check("drain_idle", rsp_valid, 1'b0);
    tick();
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!init_done && n < 100);
    check(tag, n, INIT_CYCLES + 1);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int r0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_init("init_latency");

    // Full-word write then readback, two cycles from accept to data.
    send(1'b1, 4'hF, AW'(32'h10), 32'hDEADBEEF);
    send(1'b0, 4'h0, AW'(32'h10), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", rsp_valid, 1'b0);
    tick();
    @(negedge clk);
    check("lat_cycle2", rsp_valid, 1'b1);
    check("deadbeef", rsp_rdata, 32'hDEADBEEF);
    tick();
    drain();

    // Partial byte write merges into existing data.
    send(1'b1, 4'hF, AW'(32'h11), 32'h11223344);
    send(1'b1, 4'b0010, AW'(32'h11), 32'h0000AA00);
    send(1'b0, 4'h0, AW'(32'h11), 32'h0);
    drain();
    check("byte_merge", last_rdata, 32'h1122AA44);

    // Four back-to-back reads with a free consumer.
    rsp_ready = 1'b1;
    t0 = cyc;
    r0 = n_rsp;
    for (int i = 0; i < 4; i++) send(1'b0, 4'h0, AW'(i), 32'h0);
    check("b2b_cycles", cyc - t0, 4);
    drain();
    check("b2b_count", n_rsp - r0, 4);

    // Stalled consumer: two reads fit, the third waits for one pop.
    rsp_ready = 1'b0;
    send(1'b0, 4'h0, AW'(5), 32'h0);
    send(1'b0, 4'h0, AW'(6), 32'h0);
    set_req(1'b1, 1'b0, 4'h0, AW'(7), 32'h0);
    @(negedge clk);
    check("full_ready_a", req_ready, 1'b0);
    tick();
    @(negedge clk);
    check("full_ready_b", req_ready, 1'b0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("third_accept", req_ready, 1'b1);
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    tick();
    drain();

    // Reset right after a read is accepted: its data must never appear.
    send(1'b0, 4'h0, AW'(9), 32'h0);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_cen", CEN, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_valid, 1'b0);
      tick();
    end
    if (INIT_CYCLES > 0) begin
      while (!init_done && since_rst < 100) tick();
    end

    // Randomised traffic on a small address window to force hits.
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BW'($urandom),
              AW'($urandom_range(0, 7)), $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
